instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_if.sv | 24 ++
 rtl/instr_loader.sv | 113 +++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// Instruction-loader bus: instruction-field handshake in, registered memory-write port out.
interface instr_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_opcode;
  logic [2:0]        in_type;
  logic [2:0]        in_operand;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_wdata;

  modport master (
    output in_valid, in_opcode, in_type, in_operand, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_opcode, in_type, in_operand, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Instruction loader: encodes fields into 9-bit words, buffers them and writes them to memory.
// Define INSTR_LOADER_LEGAL_CHECK_EN to drop illegal encodings and count them in err_cnt.
module instr_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_loader_if.slave     bus,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [3:0]        err_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [8:0]        fifo_q [DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ovf_q;
  logic [3:0]        err_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [8:0]        wdata_q;

  logic full, empty, xfer, illegal, push, pop, start_ok;
  logic [8:0] word;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign word     = {bus.in_opcode, bus.in_type, bus.in_operand};
  assign xfer     = bus.in_valid && bus.in_ready;
  assign push     = xfer && !illegal;
  assign pop      = !empty && ((state_q == StLoad) || (state_q == StDrain));
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));

`ifdef INSTR_LOADER_LEGAL_CHECK_EN
  assign illegal = (bus.in_opcode == 3'b111) ||
                   ((bus.in_opcode == 3'b010) && bus.in_type[2]) ||
                   ((bus.in_opcode == 3'b001) && (bus.in_type[2:1] == 2'b11));
`else
  assign illegal = 1'b0;
`endif

  // Never accept while full, even if a pop frees a slot in the same cycle.
  assign bus.in_ready  = (state_q == StLoad) && !full;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q == StLoad) || (state_q == StDrain);
  assign done          = (state_q == StDone);
  assign overflow      = ovf_q;
  assign err_cnt       = err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StLoad;
      StLoad:         if (xfer && bus.in_last) state_d = StDrain;
      // Empty here means the final word sits in the output register this cycle.
      StDrain:        if (empty) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= pop;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop) begin
        rptr_q  <= rptr_q + PW'(1);
        waddr_q <= addr_q;
        wdata_q <= fifo_q[rptr_q];
      end
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
      if (start_ok) begin
        addr_q <= base_addr;
        ovf_q  <= 1'b0;
        err_q  <= '0;
      end else begin
        if (pop) addr_q <= addr_q + ADDR_W'(1);
        if (pop && (&addr_q)) ovf_q <= 1'b1;
        if (xfer && illegal && (err_q != 4'hF)) err_q <= err_q + 4'd1;
      end
    end
  end

endmodule
